ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, is the number of clk cycles the host holds ps2_clk low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, is the maximum clk cycles allowed between successive device falling edges, and from release of clock to the first falling edge.
REQ-003 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 Port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port ps2_clk, input, 1 bit: sampled PS/2 clock line.
REQ-006 Port ps2_data, input, 1 bit: sampled PS/2 data line.
REQ-007 Port ps2_clk_oe, output, 1 bit: 1 = drive the clock line low; 0 = release.
REQ-008 Port ps2_data_oe, output, 1 bit: 1 = drive the data line low; 0 = release.
REQ-009 Port tx_data, input, 8 bits: command byte to send.
REQ-010 Port tx_valid, input, 1 bit: send request.
REQ-011 Port tx_ready, output, 1 bit: high only in IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse when a byte is acknowledged.
REQ-013 Port err, output, 1 bit: one-cycle pulse on missing ACK or timeout.

Function
REQ-014 ps2_clk and ps2_data shall be synchronized through 3 flops; a falling edge is synchronized stages [2:1] = 2'b10.
REQ-015 A transfer shall be accepted when tx_valid && tx_ready; tx_data is latched and odd parity is computed (parity = ~^tx_data).
REQ-016 State INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-017 State RTS: ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0; the timeout counter starts.
REQ-018 Falling edges 1..8 shall set ps2_data_oe = ~tx_data[i], i=0..7, LSB first; edge 9 sets ps2_data_oe = ~parity; edge 10 sets ps2_data_oe=0 (stop bit).
REQ-019 Edge 11 shall sample synchronized data: 0 = ACK, go to WAIT_IDLE; 1 = NAK, pulse err and go to IDLE.
REQ-020 WAIT_IDLE: when both synchronized lines read 1, pulse done and go to IDLE.
REQ-021 Timeout: in RTS, the bit states, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES without a qualifying event pulses err, releases both lines and returns to IDLE. The counter is cleared on every falling edge.
REQ-022 ps2_clk_oe and ps2_data_oe shall never both be 1 outside the final INHIBIT cycle. The transition to RTS asserts data_oe in the same cycle clock_oe drops.
REQ-023 tx_valid and tx_data shall be ignored while not IDLE; there is no queueing.
REQ-024 done and err shall be mutually exclusive and never held for more than 1 cycle.
REQ-025 A new request shall be accepted no earlier than the cycle after done or err.
REQ-026 Outputs are registered; ps2_data_oe updates 1 clk after the synchronized falling edge.

Reset
REQ-027 While resetn=0: state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, done=0, err=0, bit counter=0, timeout counter=0, synchronizers=3'b111.
REQ-028 Reset asserted mid-transfer shall release both lines immediately (asynchronously) and abandon the byte without pulsing done or err.

Verification
REQ-029 Send 0xED with a device model that ACKs -> clock held low 5000 cycles, then data bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen at device rising edges; done pulses once; err stays 0.
REQ-030 Send 0x00, then 0x01 -> parity bits 1 and 0 respectively; two done pulses.
REQ-031 Device model holds data high at the ACK clock -> err pulses once, no done, tx_ready=1 next cycle.
REQ-032 Device never clocks after RTS (TIMEOUT_CYCLES=1000 in sim) -> err pulses 1000 cycles after RTS entry, both oe=0.
REQ-033 resetn pulled low after 4th data bit -> both oe=0 immediately; after release, tx_ready=1, and a following 0xF4 transfer completes with done.
REQ-034 tx_valid held high with changing tx_data during a transfer -> only the latched byte is sent; the next byte starts after done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a command byte out on device clock falling edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e           r_state;
  logic [2:0]       r_clk_sync;
  logic [2:0]       r_data_sync;
  logic [8:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_tx_ready;
  logic             r_done;
  logic             r_err;

  logic w_fall;
  logic w_lines_idle;
  logic w_active;
  logic w_event;
  logic w_timeout;

  assign w_fall       = (r_clk_sync[2:1] == 2'b10);
  assign w_lines_idle = r_clk_sync[2] & r_data_sync[2];
  assign w_active     = r_state inside {S_RTS, S_BITS, S_ACK, S_WAIT_IDLE};
  // The qualifying event that restarts the watchdog differs only in WAIT_IDLE.
  assign w_event      = (r_state == S_WAIT_IDLE) ? w_lines_idle : w_fall;
  assign w_timeout    = w_active && !w_event && (r_cnt == TIMEOUT_LAST);

  // NOTE: the async reset branch releases both open-drain lines the instant
  // resetn falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_cnt       <= '0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees pre-edge values.
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[1:0], ps2_data};
      r_done      <= 1'b0;
      r_err       <= 1'b0;

      if (w_timeout) begin
        r_err      <= 1'b1;
        r_clk_oe   <= 1'b0;
        r_data_oe  <= 1'b0;
        r_state    <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tx_ready <= 1'b1;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            if (tx_valid && r_tx_ready) begin
              r_shift    <= {~^tx_data, tx_data};
              r_tx_ready <= 1'b0;
              r_clk_oe   <= 1'b1;
              r_state    <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            if (r_cnt == INHIBIT_LAST) begin
              r_cnt     <= '0;
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b1;
              r_state   <= S_RTS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          // Shift register is back-filled with ones so edge 10 drives the stop bit.
          S_RTS, S_BITS: begin
            if (w_fall) begin
              r_cnt     <= '0;
              r_data_oe <= ~r_shift[0];
              r_shift   <= {1'b1, r_shift[8:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_state   <= (r_bit_cnt == 4'd9) ? S_ACK : S_BITS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_ACK: begin
            if (w_fall) begin
              r_cnt <= '0;
              if (!r_data_sync[2]) begin
                r_state <= S_WAIT_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_WAIT_IDLE: begin
            if (w_lines_idle) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_ready    = r_tx_ready;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares the sampled bits against frames queued when each request is driven.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INHIBIT = 5000;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, overlap_cnt = 0, long_cnt = 0, both_oe_cnt = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;
  logic [9:0] exp_q[$];

  // Open-drain lines with pull-ups.
  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) overlap_cnt++;
      if ((done && prev_done) || (err && prev_err)) long_cnt++;
      if (ps2_clk_oe && ps2_data_oe) both_oe_cnt++;
    end
    prev_done = done;
    prev_err  = err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  task automatic request(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL request_ready: tx_ready=%b required 1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back(frame_of(b));
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Device model: measures inhibit, clocks n_bits bits, optionally the ACK edge.
  task automatic device_frame(input int n_bits, input bit ack, input bit finish,
                              output logic [9:0] bits, output int inhibit_len);
    int n;
    bits = '0;
    inhibit_len = 0;
    @(negedge clk);
    n = 0;
    while (ps2_clk_oe && n < 4 * INHIBIT) begin inhibit_len++; @(negedge clk); n++; end
    repeat (2 * HALF) @(negedge clk);
    for (int i = 0; i < n_bits; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[i] = ps2_data;
      repeat (HALF) @(negedge clk);
    end
    if (finish) begin
      dev_data_low = ack;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_data_low = 1'b0;
      n = 0;
      while (!done && !err && n < 8 * HALF) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pop_expected(output logic [9:0] exp);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    else exp = 'x;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    checks++;
    if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b required 0", ps2_clk_oe); end
    checks++;
    if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b required 0", ps2_data_oe); end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: done=%b err=%b required 0 0", done, err);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ack;
    int d0, e0, inh;
    logic [9:0] bits, exp;
    d0 = done_cnt; e0 = err_cnt;
    request(8'hED);
    device_frame(10, 1'b1, 1'b1, bits, inh);
    pop_expected(exp);
    checks++;
    if (inh !== INHIBIT) begin errors++; $display("FAIL inhibit_len: got %0d required %0d", inh, INHIBIT); end
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL frame_ED: got %b required %b", bits, exp); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL done_ED: got %0d pulses required 1", done_cnt - d0); end
    checks++;
    if (err_cnt - e0 !== 0) begin errors++; $display("FAIL err_ED: got %0d pulses required 0", err_cnt - e0); end
  endtask

  task automatic test_parity;
    int d0, inh;
    logic [9:0] bits0, bits1, exp;
    d0 = done_cnt;
    request(8'h00);
    device_frame(10, 1'b1, 1'b1, bits0, inh);
    request(8'h01);
    device_frame(10, 1'b1, 1'b1, bits1, inh);
    pop_expected(exp);
    checks++;
    if (bits0 !== exp) begin errors++; $display("FAIL frame_00: got %b required %b", bits0, exp); end
    checks++;
    if (bits0[8] !== 1'b1) begin errors++; $display("FAIL parity_00: got %b required 1", bits0[8]); end
    pop_expected(exp);
    checks++;
    if (bits1 !== exp) begin errors++; $display("FAIL frame_01: got %b required %b", bits1, exp); end
    checks++;
    if (bits1[8] !== 1'b0) begin errors++; $display("FAIL parity_01: got %b required 0", bits1[8]); end
    checks++;
    if (done_cnt - d0 !== 2) begin errors++; $display("FAIL done_parity: got %0d pulses required 2", done_cnt - d0); end
  endtask

  task automatic test_nak;
    int d0, e0, inh;
    logic [9:0] bits, exp;
    logic ready_after, err_after;
    d0 = done_cnt; e0 = err_cnt;
    ready_after = 1'b0; err_after = 1'b1;
    request(8'hA7);
    fork
      device_frame(10, 1'b0, 1'b1, bits, inh);
      begin
        int n;
        n = 0;
        while (!err && n < 20000) begin @(negedge clk); n++; end
        @(negedge clk);
        ready_after = tx_ready;
        err_after   = err;
      end
    join
    pop_expected(exp);
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL frame_nak: got %b required %b", bits, exp); end
    checks++;
    if (ready_after !== 1'b1) begin errors++; $display("FAIL nak_ready: got %b required 1", ready_after); end
    checks++;
    if (err_after !== 1'b0) begin errors++; $display("FAIL nak_err_width: got %b required 0", err_after); end
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL nak_pulses: err=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout;
    int d0, e0, n;
    logic [9:0] exp;
    d0 = done_cnt; e0 = err_cnt;
    request(8'h12);
    @(negedge clk);
    n = 0;
    while (ps2_clk_oe && n < 4 * INHIBIT) begin @(negedge clk); n++; end
    checks++;
    if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL rts_data_oe: got %b required 1", ps2_data_oe); end
    n = 0;
    while (!err && n < 5 * TIMEOUT) begin @(negedge clk); n++; end
    checks++;
    if (n !== TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d required %0d", n, TIMEOUT); end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    pop_expected(exp);
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL timeout_pulses: err=%0d done=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int d0, e0, inh;
    logic [9:0] bits, exp;
    d0 = done_cnt; e0 = err_cnt;
    request(8'h00);
    device_frame(4, 1'b0, 1'b0, bits, inh);
    pop_expected(exp);
    checks++;
    if (bits[3:0] !== exp[3:0]) begin errors++; $display("FAIL frame_partial: got %b required %b", bits[3:0], exp[3:0]); end
    checks++;
    if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL mid_data_oe: got %b required 1", ps2_data_oe); end
    resetn = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL async_release: clk_oe=%b data_oe=%b required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", tx_ready); end
    checks++;
    if (err_cnt - e0 !== 0 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL abandon_pulses: err=%0d done=%0d required 0 0", err_cnt - e0, done_cnt - d0);
    end
    d0 = done_cnt;
    request(8'hF4);
    device_frame(10, 1'b1, 1'b1, bits, inh);
    pop_expected(exp);
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL frame_F4: got %b required %b", bits, exp); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL done_F4: got %0d pulses required 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    int d0, n, inh;
    logic [9:0] bits_a, bits_b, exp;
    d0 = done_cnt;
    n = 0;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(frame_of(8'h3C));
    @(posedge clk); #1;
    fork
      device_frame(10, 1'b1, 1'b1, bits_a, inh);
      begin
        int k;
        k = 0;
        while (!done && k < 20000) begin
          tx_data = 8'($urandom);
          @(negedge clk);
          k++;
        end
        tx_data = 8'h5A;
        exp_q.push_back(frame_of(8'h5A));
      end
    join
    tx_valid = 1'b0;
    device_frame(10, 1'b1, 1'b1, bits_b, inh);
    pop_expected(exp);
    checks++;
    if (bits_a !== exp) begin errors++; $display("FAIL latched_byte: got %b required %b", bits_a, exp); end
    pop_expected(exp);
    checks++;
    if (bits_b !== exp) begin errors++; $display("FAIL next_byte: got %b required %b", bits_b, exp); end
    checks++;
    if (done_cnt - d0 !== 2) begin errors++; $display("FAIL done_b2b: got %0d pulses required 2", done_cnt - d0); end
  endtask

  task automatic test_invariants;
    checks++;
    if (overlap_cnt !== 0) begin errors++; $display("FAIL done_err_overlap: got %0d required 0", overlap_cnt); end
    checks++;
    if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses required 0", long_cnt); end
    checks++;
    if (both_oe_cnt !== 0) begin errors++; $display("FAIL both_oe: got %0d cycles required 0", both_oe_cnt); end
  endtask

  initial begin
    test_reset();
    test_send_ack();
    test_parity();
    test_nak();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
